// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type, address alignment and memory-stage FSM state
package cpu_types_pkg;
  localparam int WORD_W    = 32;
  localparam int ALIGN_LSB = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {IDLE, DONE} mem_state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - dcache request/response and coherence snoop bundle
interface mem_access_ctrl_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;
  logic  ccinv;
  word_t ccsnoopaddr;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload, ccinv, ccsnoopaddr
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/mem_access_ctrl_ll_sc_link.sv
// rtl/mem_access_ctrl_ll_sc_link.sv - LL/SC link register, cleared by snoop invalidates and local stores
module ll_sc_link
  import cpu_types_pkg::*;
#(
  parameter int ALIGN_LSB = cpu_types_pkg::ALIGN_LSB
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  logic  st_clr,
  input  word_t addr,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  output logic  sc_ok
);

  word_t link_addr;
  logic  link_valid;

  function automatic logic same_word(input word_t a, input word_t b);
    return ((a ^ b) >> ALIGN_LSB) == '0;
  endfunction

  // A snoop hitting the word being linked in the same cycle leaves the link invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_addr  <= '0;
      link_valid <= 1'b0;
    end else if (set) begin
      link_addr  <= addr;
      link_valid <= !(ccinv && same_word(ccsnoopaddr, addr));
    end else if ((ccinv && same_word(ccsnoopaddr, link_addr)) ||
                 (st_clr && same_word(addr, link_addr))) begin
      link_valid <= 1'b0;
    end
  end

  assign sc_ok = link_valid && same_word(link_addr, addr);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage controller: dcache request, pipeline stall, load data and LL/SC
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ALIGN_LSB = cpu_types_pkg::ALIGN_LSB
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      dREN_i,
  input  logic                      dWEN_i,
  input  logic                      datomic_i,
  input  word_t                     addr_i,
  input  word_t                     store_dat_i,
  mem_access_ctrl_if.master         dc,
  output logic                      mem_stall,
  output word_t                     load_dat_o,
  output logic                      mem_done_o
);

  mem_state_t state;
  logic ren, wen, issue, is_ll, is_sc, sc_ok, sc_fail, hit;

  // A store request overrides a simultaneous load request.
  assign wen     = dWEN_i;
  assign ren     = dREN_i & ~dWEN_i;
  assign issue   = nRST && (state == IDLE) && (ren || wen);
  assign is_ll   = ren & datomic_i;
  assign is_sc   = wen & datomic_i;
  assign sc_fail = issue & is_sc & ~sc_ok;
  assign hit     = issue & dc.dhit & ~sc_fail;

  assign dc.dmemREN   = issue & ren;
  assign dc.dmemWEN   = issue & wen & (~datomic_i | sc_ok);
  assign dc.dmemaddr  = issue ? addr_i : '0;
  assign dc.dmemstore = issue ? store_dat_i : '0;
  assign mem_stall    = issue;
  assign mem_done_o   = (state == DONE);

  ll_sc_link #(.ALIGN_LSB(ALIGN_LSB)) u_link (
    .CLK         (CLK),
    .nRST        (nRST),
    .set         (hit & is_ll),
    .st_clr      (hit & wen),
    .addr        (addr_i),
    .ccinv       (dc.ccinv),
    .ccsnoopaddr (dc.ccsnoopaddr),
    .sc_ok       (sc_ok)
  );

  // A failed SC completes without touching the cache and reports 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      load_dat_o <= '0;
    end else begin
      if (sc_fail) begin
        state      <= DONE;
        load_dat_o <= '0;
      end else if (hit) begin
        state <= DONE;
        if (ren)
          load_dat_o <= dc.dmemload;
        else if (is_sc)
          load_dat_o <= word_t'(1);
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
